// File: rtl/flood_sequencer.sv
// rtl/flood_sequencer.sv - Flood-It move sequencer: recolours the owned region, then grows it
// Owned-cell bitmap lives here; the board RAM holds colours only.
module flood_sequencer #(
  parameter int MAX_SIZE = 26,
  parameter int COLOR_W  = 3,
  parameter int MOVE_W   = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_init,
  input  logic [4:0]         i_size,
  input  logic               i_start,
  input  logic [COLOR_W-1:0] i_color,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_win,
  output logic [MOVE_W-1:0]  o_moves,
  output logic [4:0]         o_rd_row,
  output logic [4:0]         o_rd_col,
  input  logic [COLOR_W-1:0] i_rd_data,
  output logic               o_wr_en,
  output logic [4:0]         o_wr_row,
  output logic [4:0]         o_wr_col,
  output logic [COLOR_W-1:0] o_wr_data
);
  localparam int CELLS = MAX_SIZE * MAX_SIZE;
  localparam logic [4:0] MAX_RC = 5'(MAX_SIZE);
  localparam logic [9:0] ROW_STEP = 10'(MAX_SIZE);

  typedef enum logic [2:0] {S_IDLE, S_SEED, S_RECOLOR, S_EXPAND, S_CHECK, S_FIN} state_t;

  state_t             r_state, w_next;
  logic [4:0]         r_size, r_row, r_col, r_ev_row, r_ev_col;
  logic [COLOR_W-1:0] r_regcol;
  logic [MOVE_W-1:0]  r_moves;
  logic [9:0]         r_cnt;
  logic [CELLS-1:0]   r_owned;
  logic               r_win, r_active, r_seed_ph, r_iss, r_ev_vld, r_changed;

  logic [4:0] w_lim, w_size_clamp, w_nrow, w_ncol;
  logic [9:0] w_eidx, w_widx, w_area;
  logic       w_last, w_nb, w_grow, w_sweep_end, w_start_ok, w_noop;

  function automatic logic [9:0] cell_idx(input logic [4:0] row, input logic [4:0] col);
    return 10'(row) * ROW_STEP + 10'(col);
  endfunction

  assign w_lim        = r_size - 5'd1;
  assign w_size_clamp = (i_size < 5'd2) ? 5'd2 : ((i_size > MAX_RC) ? MAX_RC : i_size);
  assign w_last       = (r_row == w_lim) && (r_col == w_lim);
  assign w_ncol       = (r_col == w_lim) ? 5'd0 : r_col + 5'd1;
  assign w_nrow       = (r_col == w_lim) ? r_row + 5'd1 : r_row;
  assign w_eidx       = cell_idx(r_ev_row, r_ev_col);
  assign w_widx       = cell_idx(r_row, r_col);
  assign w_area       = 10'(r_size) * 10'(r_size);

  // Neighbour lookups see bits set earlier in the same sweep.
  assign w_nb = ((r_ev_row != 5'd0) && r_owned[w_eidx - ROW_STEP]) ||
                ((r_ev_row != w_lim) && r_owned[w_eidx + ROW_STEP]) ||
                ((r_ev_col != 5'd0) && r_owned[w_eidx - 10'd1]) ||
                ((r_ev_col != w_lim) && r_owned[w_eidx + 10'd1]);
  assign w_grow      = (r_state == S_EXPAND) && r_ev_vld && !r_owned[w_eidx] &&
                       (i_rd_data == r_regcol) && w_nb;
  assign w_sweep_end = !r_iss && r_ev_vld;
  assign w_start_ok  = i_start && r_active && !r_win;
  assign w_noop      = (i_color == r_regcol);

  assign o_busy    = (r_state != S_IDLE);
  assign o_done    = (r_state == S_FIN);
  assign o_win     = r_win;
  assign o_moves   = r_moves;
  assign o_rd_row  = r_row;
  assign o_rd_col  = r_col;
  assign o_wr_en   = (r_state == S_RECOLOR) && r_owned[w_widx];
  assign o_wr_row  = r_row;
  assign o_wr_col  = r_col;
  assign o_wr_data = r_regcol;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (i_init)          w_next = S_SEED;
        else if (w_start_ok) w_next = w_noop ? S_FIN : S_RECOLOR;
      end
      S_SEED:    if (r_seed_ph) w_next = S_EXPAND;
      S_RECOLOR: if (w_last) w_next = S_EXPAND;
      S_EXPAND:  if (w_sweep_end && !(r_changed || w_grow)) w_next = S_CHECK;
      S_CHECK:   w_next = S_FIN;
      S_FIN:     w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_size    <= 5'd2;
      r_row     <= 5'd0;
      r_col     <= 5'd0;
      r_ev_row  <= 5'd0;
      r_ev_col  <= 5'd0;
      r_regcol  <= '0;
      r_moves   <= '0;
      r_cnt     <= 10'd0;
      r_owned   <= '0;
      r_win     <= 1'b0;
      r_active  <= 1'b0;
      r_seed_ph <= 1'b0;
      r_iss     <= 1'b0;
      r_ev_vld  <= 1'b0;
      r_changed <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (i_init) begin
            r_size     <= w_size_clamp;
            r_owned    <= '0;
            r_owned[0] <= 1'b1;
            r_cnt      <= 10'd1;
            r_moves    <= '0;
            r_win      <= 1'b0;
            r_active   <= 1'b1;
            r_seed_ph  <= 1'b0;
            r_row      <= 5'd0;
            r_col      <= 5'd0;
          end else if (w_start_ok && !w_noop) begin
            r_moves  <= (r_moves == '1) ? r_moves : r_moves + MOVE_W'(1);
            r_regcol <= i_color;
            r_row    <= 5'd0;
            r_col    <= 5'd0;
          end
        end
        S_SEED: begin
          r_seed_ph <= !r_seed_ph;
          if (r_seed_ph) begin
            r_regcol  <= i_rd_data;
            r_iss     <= 1'b1;
            r_ev_vld  <= 1'b0;
            r_changed <= 1'b0;
          end
        end
        S_RECOLOR: begin
          if (w_last) begin
            r_row     <= 5'd0;
            r_col     <= 5'd0;
            r_iss     <= 1'b1;
            r_ev_vld  <= 1'b0;
            r_changed <= 1'b0;
          end else begin
            r_row <= w_nrow;
            r_col <= w_ncol;
          end
        end
        S_EXPAND: begin
          r_ev_vld  <= r_iss;
          r_ev_row  <= r_row;
          r_ev_col  <= r_col;
          r_changed <= w_sweep_end ? 1'b0 : (r_changed || w_grow);
          if (w_grow) begin
            r_owned[w_eidx] <= 1'b1;
            r_cnt           <= r_cnt + 10'd1;
          end
          if (r_iss) begin
            if (w_last) begin
              r_iss <= 1'b0;
            end else begin
              r_row <= w_nrow;
              r_col <= w_ncol;
            end
          end else if (w_sweep_end && (r_changed || w_grow)) begin
            r_row <= 5'd0;
            r_col <= 5'd0;
            r_iss <= 1'b1;
          end
        end
        S_CHECK: r_win <= (r_cnt == w_area);
        S_FIN:   ;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_flood_sequencer.sv
// tb/tb_flood_sequencer.sv - randomized scoreboard bench for flood_sequencer
// Reference model recomputes the flooded region by breadth-first fill of the board.
module tb_flood_sequencer;
  localparam int MS = 26;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       init = 1'b0, start = 1'b0;
  logic [4:0] size = 5'd0;
  logic [2:0] color = 3'd0;
  logic       busy, done, win, wr_en;
  logic [7:0] moves;
  logic [4:0] rd_row, rd_col, wr_row, wr_col;
  logic [2:0] rd_data = 3'd0, wr_data;

  always #5 clk = ~clk;

  flood_sequencer dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_init(init), .i_size(size), .i_start(start),
    .i_color(color), .o_busy(busy), .o_done(done), .o_win(win), .o_moves(moves),
    .o_rd_row(rd_row), .o_rd_col(rd_col), .i_rd_data(rd_data), .o_wr_en(wr_en),
    .o_wr_row(wr_row), .o_wr_col(wr_col), .o_wr_data(wr_data)
  );

  logic [2:0] mem [0:MS-1][0:MS-1];
  logic [2:0] ref_board [0:MS-1][0:MS-1];
  bit         comp [0:MS-1][0:MS-1];
  logic       load_req = 1'b0;

  // Board RAM: one-cycle read latency; bench loads a fresh board via load_req.
  always @(posedge clk) begin
    rd_data <= mem[rd_row][rd_col];
    if (load_req) begin
      for (int r = 0; r < MS; r++)
        for (int c = 0; c < MS; c++) mem[r][c] <= ref_board[r][c];
    end else if (wr_en) begin
      mem[wr_row][wr_col] <= wr_data;
    end
  end

  typedef struct { int row; int col; int data; } wr_t;
  typedef struct { int moves; int win; int lat; int issue; } done_t;
  wr_t   exp_wr[$];
  done_t exp_done[$];

  int n_vec = 0, n_err = 0, cyc = 0;
  int ref_size = 2, ref_regcol = 0, ref_moves = 0, ref_win = 0, ref_active = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic int flood_fill();
    int q[$];
    int n, r, c, k;
    for (int i = 0; i < MS; i++)
      for (int j = 0; j < MS; j++) comp[i][j] = 0;
    comp[0][0] = 1;
    q.push_back(0);
    n = 1;
    while (q.size() > 0) begin
      k = q.pop_front();
      r = k / MS;
      c = k % MS;
      for (int d = 0; d < 4; d++) begin
        int nr, nc;
        nr = r + ((d == 0) ? -1 : (d == 1) ? 1 : 0);
        nc = c + ((d == 2) ? -1 : (d == 3) ? 1 : 0);
        if (nr >= 0 && nr < ref_size && nc >= 0 && nc < ref_size && !comp[nr][nc] &&
            int'(ref_board[nr][nc]) == ref_regcol) begin
          comp[nr][nc] = 1;
          n++;
          q.push_back(nr * MS + nc);
        end
      end
    end
    return n;
  endfunction

  task automatic model_init(input int sz);
    done_t d;
    ref_size   = (sz < 2) ? 2 : (sz > MS) ? MS : sz;
    ref_active = 1;
    ref_moves  = 0;
    ref_regcol = int'(ref_board[0][0]);
    ref_win    = (flood_fill() == ref_size * ref_size) ? 1 : 0;
    d.moves = 0; d.win = ref_win; d.lat = -1; d.issue = cyc;
    exp_done.push_back(d);
  endtask

  task automatic model_start(input int c);
    wr_t   w;
    done_t d;
    if (!ref_active || ref_win != 0) return;
    d.lat = -1;
    d.issue = cyc;
    if (c == ref_regcol) begin
      d.lat = 1;
    end else begin
      void'(flood_fill());
      for (int r = 0; r < ref_size; r++)
        for (int k = 0; k < ref_size; k++)
          if (comp[r][k]) begin
            w.row = r; w.col = k; w.data = c;
            exp_wr.push_back(w);
            ref_board[r][k] = 3'(c);
          end
      ref_regcol = c;
      if (ref_moves < 255) ref_moves++;
      ref_win = (flood_fill() == ref_size * ref_size) ? 1 : 0;
    end
    d.moves = ref_moves;
    d.win = ref_win;
    exp_done.push_back(d);
  endtask

  // Monitor: pops expected writes and completions as the DUT presents them.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) begin
        if (exp_wr.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_write: got (%0d,%0d)=%0d, expected no write", wr_row, wr_col, wr_data);
        end else begin
          wr_t w;
          w = exp_wr.pop_front();
          check("wr_row", int'(wr_row), w.row);
          check("wr_col", int'(wr_col), w.col);
          check("wr_data", int'(wr_data), w.data);
        end
      end
      if (busy) check("rd_in_bounds", int'(rd_row < 5'(ref_size) && rd_col < 5'(ref_size)), 1);
      if (done) begin
        if (exp_done.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_done: got done with moves %0d, expected none", moves);
        end else begin
          done_t d;
          d = exp_done.pop_front();
          check("done_moves", int'(moves), d.moves);
          check("done_win", int'(win), d.win);
          check("writes_drained", exp_wr.size(), 0);
          if (d.lat >= 0) check("done_latency", cyc - d.issue, d.lat);
        end
      end
    end
  end

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while (exp_done.size() != 0 && t < 20000) begin
      @(posedge clk);
      t++;
    end
    if (exp_done.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL %s_timeout: got %0d pending responses, expected 0", name, exp_done.size());
      exp_done.delete();
      exp_wr.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic do_init(input int sz);
    @(posedge clk); #1;
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
    init = 1'b1;
    size = 5'(sz);
    model_init(sz);
    @(posedge clk); #1;
    init = 1'b0;
    wait_done("init");
  endtask

  task automatic pulse_start(input int c, input bit modeled);
    @(posedge clk); #1;
    start = 1'b1;
    color = 3'(c);
    if (modeled) model_start(c);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic fill_random(input int ncol);
    for (int r = 0; r < MS; r++)
      for (int c = 0; c < MS; c++) ref_board[r][c] = 3'($urandom_range(0, ncol - 1));
  endtask

  initial begin
    int sz, nc;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_win", int'(win), 0);
    check("rst_moves", int'(moves), 0);
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_rd_row", int'(rd_row), 0);
    check("rst_rd_col", int'(rd_col), 0);
    rst_n = 1'b1;

    pulse_start(3, 1);
    repeat (10) @(posedge clk);
    check("start_before_init_busy", int'(busy), 0);

    // 4x4 checkerboard of colours 1/2
    for (int r = 0; r < MS; r++)
      for (int c = 0; c < MS; c++) ref_board[r][c] = ((r + c) % 2 == 0) ? 3'd1 : 3'd2;
    do_init(4);
    check("ckb_busy_after", int'(busy), 0);
    pulse_start(2, 1); wait_done("ckb_move");
    check("ckb_moves", int'(moves), 1);
    pulse_start(2, 1); wait_done("ckb_noop");
    pulse_start(1, 1); wait_done("ckb_move2");

    // 3x3 two-colour board won in one move
    for (int r = 0; r < MS; r++)
      for (int c = 0; c < MS; c++) ref_board[r][c] = 3'd1;
    ref_board[0][0] = 3'd0; ref_board[1][0] = 3'd0;
    ref_board[2][0] = 3'd0; ref_board[2][1] = 3'd0;
    do_init(3);
    pulse_start(1, 1); wait_done("win_move");
    check("win_flag", int'(win), 1);
    pulse_start(0, 1);
    repeat (10) @(posedge clk);
    check("win_start_ignored_busy", int'(busy), 0);
    check("win_moves_hold", int'(moves), 1);

    // random games, including clamped sizes 0 and 1
    for (int g = 0; g < 7; g++) begin
      sz = (g == 0) ? 0 : (g == 1) ? 1 : $urandom_range(2, 6);
      nc = $urandom_range(2, 4);
      fill_random(nc);
      do_init(sz);
      for (int m = 0; m < 20 && ref_win == 0; m++) begin
        pulse_start($urandom_range(0, nc - 1), 1);
        wait_done("rand_move");
      end
      if (ref_win != 0) begin
        pulse_start($urandom_range(0, nc - 1), 1);
        repeat (8) @(posedge clk);
        check("rand_win_hold", int'(moves), ref_moves);
      end
    end

    // SIZE above MAX_SIZE on a uniform board: clamps to 26 and wins at INIT
    for (int r = 0; r < MS; r++)
      for (int c = 0; c < MS; c++) ref_board[r][c] = 3'd4;
    do_init(31);
    check("clamp_win", int'(win), 1);

    // INIT and START together, then START while busy
    fill_random(3);
    @(posedge clk); #1;
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
    init = 1'b1; start = 1'b1; size = 5'd5; color = 3'(ref_board[0][0] + 3'd1);
    model_init(5);
    @(posedge clk); #1;
    init = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    check("busy_during_init", int'(busy), 1);
    pulse_start(int'(ref_board[0][0] + 3'd2), 0);
    wait_done("init_start");
    repeat (20) @(posedge clk);
    check("init_start_moves", int'(moves), 0);

    // saturation: region can never grow, alternate colours 1/2
    for (int r = 0; r < MS; r++)
      for (int c = 0; c < MS; c++) ref_board[r][c] = 3'd5;
    ref_board[0][0] = 3'd0;
    do_init(2);
    for (int m = 0; m < 256; m++) begin
      pulse_start((m % 2 == 0) ? 1 : 2, 1);
      wait_done("sat_move");
    end
    check("sat_moves", int'(moves), 255);

    // asynchronous reset in the middle of an EXPAND sweep on 6x6
    fill_random(3);
    do_init(6);
    pulse_start((ref_regcol + 1) % 3, 1);
    repeat (40) @(posedge clk);
    #1;
    check("mid_busy", int'(busy), 1);
    check("mid_wr_en_expand", int'(wr_en), 0);
    rst_n = 1'b0;
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_moves", int'(moves), 0);
    check("arst_wr_en", int'(wr_en), 0);
    check("arst_done", int'(done), 0);
    exp_wr.delete();
    exp_done.delete();
    ref_active = 0; ref_win = 0; ref_moves = 0; ref_regcol = 0; ref_size = 2;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    pulse_start(2, 1);
    repeat (50) @(posedge clk);
    check("post_rst_start_busy", int'(busy), 0);
    check("post_rst_moves", int'(moves), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
